// File: rtl/adder_tree_acc.sv
// Reduction stage after the 16-lane multiplier: 4-level registered adder tree
// followed by a group accumulator that emits one saturated result per group.
module adder_tree_acc #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ACC_WIDTH = 48,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [15:0][WIDTH-1:0]     in_data,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_sat,
   output logic [CNT_WIDTH-1:0]       out_beats,
   output logic                       busy
);

   localparam int unsigned W1 = WIDTH + 1;
   localparam int unsigned W2 = WIDTH + 2;
   localparam int unsigned W3 = WIDTH + 3;
   localparam int unsigned W4 = WIDTH + 4;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   logic adv;

   logic                 s1_valid, s1_last;
   logic signed [W1-1:0] s1_sum [8];
   logic                 s2_valid, s2_last;
   logic signed [W2-1:0] s2_sum [4];
   logic                 s3_valid, s3_last;
   logic signed [W3-1:0] s3_sum [2];
   logic                 s4_valid, s4_last;
   logic signed [W4-1:0] s4_sum;

   state_t state, state_next;

   logic signed [ACC_WIDTH-1:0] acc, acc_next;
   logic [CNT_WIDTH-1:0]        beats, beats_next;
   logic                        emit;
   logic                        sat_hi, sat_lo;
   logic [WIDTH-1:0]            data_next;

   // Whole pipeline stalls only when a result is held and not taken.
   assign adv      = !out_valid || out_ready;
   assign in_ready = rst_n & adv;
   assign busy     = s1_valid | s2_valid | s3_valid | s4_valid | (state == ACC) | out_valid;

   // Adder tree; operands are sign-extended one bit per level so no stage can overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s3_valid <= 1'b0;
         s3_last  <= 1'b0;
         s4_valid <= 1'b0;
         s4_last  <= 1'b0;
         s4_sum   <= '0;
         for (int i = 0; i < 8; i++) s1_sum[i] <= '0;
         for (int i = 0; i < 4; i++) s2_sum[i] <= '0;
         for (int i = 0; i < 2; i++) s3_sum[i] <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_last  <= in_valid & in_last;
         for (int i = 0; i < 8; i++) begin
            s1_sum[i] <= W1'($signed(in_data[2*i])) + W1'($signed(in_data[2*i+1]));
         end
         s2_valid <= s1_valid;
         s2_last  <= s1_last;
         for (int i = 0; i < 4; i++) begin
            s2_sum[i] <= W2'(s1_sum[2*i]) + W2'(s1_sum[2*i+1]);
         end
         s3_valid <= s2_valid;
         s3_last  <= s2_last;
         for (int i = 0; i < 2; i++) begin
            s3_sum[i] <= W3'(s2_sum[2*i]) + W3'(s2_sum[2*i+1]);
         end
         s4_valid <= s3_valid;
         s4_last  <= s3_last;
         s4_sum   <= W4'(s3_sum[0]) + W4'(s3_sum[1]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Group open/close tracking.
   always_comb begin
      state_next = state;
      if (adv && s4_valid) begin
         case (state)
            IDLE:    if (!s4_last) state_next = ACC;
            ACC:     if (s4_last)  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Accumulate, count beats and form the saturated result.
   always_comb begin
      acc_next   = acc;
      beats_next = beats;
      emit       = 1'b0;
      sat_hi     = 1'b0;
      sat_lo     = 1'b0;
      data_next  = '0;
      if (adv && s4_valid) begin
         emit = s4_last;
         if (state == IDLE) begin
            acc_next   = ACC_WIDTH'(s4_sum);
            beats_next = CNT_WIDTH'(1);
         end else begin
            acc_next   = acc + ACC_WIDTH'(s4_sum);
            beats_next = (&beats) ? beats : beats + CNT_WIDTH'(1);
         end
      end
      sat_hi    = ~acc_next[ACC_WIDTH-1] &  (|acc_next[ACC_WIDTH-2:WIDTH-1]);
      sat_lo    =  acc_next[ACC_WIDTH-1] & ~(&acc_next[ACC_WIDTH-2:WIDTH-1]);
      data_next = sat_hi ? {1'b0, {(WIDTH-1){1'b1}}} :
                  sat_lo ? {1'b1, {(WIDTH-1){1'b0}}} :
                           acc_next[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= '0;
         beats     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_beats <= '0;
      end else begin
         acc   <= acc_next;
         beats <= beats_next;
         if (adv) begin
            out_valid <= emit;
            if (emit) begin
               out_data  <= data_next;
               out_sat   <= sat_hi | sat_lo;
               out_beats <= beats_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench for adder_tree_acc: a behavioural group model pushes the
// expected result on every accepted last vector; a monitor pops on each handshake.
module tb_adder_tree_acc;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned ACC_WIDTH = 48;
   localparam int unsigned CNT_WIDTH = 16;

   typedef struct packed {
      logic [WIDTH-1:0]     data;
      logic                 sat;
      logic [CNT_WIDTH-1:0] beats;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [15:0][WIDTH-1:0] in_data;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready = 1'b1;
   logic [WIDTH-1:0]       out_data;
   logic                   out_sat;
   logic [CNT_WIDTH-1:0]   out_beats;
   logic                   busy;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   longint      cyc = 0;
   longint      t_acc = 0;
   longint      m_acc = 0;
   int          m_beats = 0;
   bit          m_open = 1'b0;
   bit          rdy_rand = 1'b0;
   bit          rdy_fixed = 1'b1;

   adder_tree_acc #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_beats (out_beats),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(1, 0)) : rdy_fixed;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint wrap_acc(input longint v);
      logic [63:0] t;
      t = v;
      return longint'({{(64-ACC_WIDTH){t[ACC_WIDTH-1]}}, t[ACC_WIDTH-1:0]});
   endfunction

   // Reference group model, advanced once per accepted vector.
   function automatic void model_accept(input logic [15:0][WIDTH-1:0] v, input logic last);
      longint s;
      exp_t   e;
      s = 0;
      for (int i = 0; i < 16; i++) s += longint'($signed(v[i]));
      if (!m_open) begin
         m_acc   = wrap_acc(s);
         m_beats = 1;
      end else begin
         m_acc   = wrap_acc(m_acc + s);
         m_beats = (m_beats == 65535) ? 65535 : m_beats + 1;
      end
      if (last) begin
         if (m_acc > 64'sd2147483647) begin
            e.data = 32'h7FFF_FFFF;
            e.sat  = 1'b1;
         end else if (m_acc < -64'sd2147483648) begin
            e.data = 32'h8000_0000;
            e.sat  = 1'b1;
         end else begin
            e.data = 32'(m_acc);
            e.sat  = 1'b0;
         end
         e.beats = 16'(m_beats);
         sb.push_back(e);
         m_open = 1'b0;
      end else begin
         m_open = 1'b1;
      end
   endfunction

   // Called at posedge+1; returns at posedge+1 after the vector is accepted.
   task automatic send(input logic [15:0][WIDTH-1:0] v, input logic last);
      int k;
      in_valid = 1'b1;
      in_data  = v;
      in_last  = last;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 300) begin
         k++;
         @(negedge clk);
      end
      if (!in_ready) begin
         check("in_ready_timeout", 64'(in_ready), 64'(1));
      end else begin
         t_acc = cyc;
         model_accept(v, last);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   function automatic logic [15:0][WIDTH-1:0] fill(input logic [WIDTH-1:0] x);
      logic [15:0][WIDTH-1:0] v;
      for (int i = 0; i < 16; i++) v[i] = x;
      return v;
   endfunction

   // Output monitor: every handshake must match the oldest expected group.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("out_data",  64'(out_data),  64'(mon_e.data));
            check("out_sat",   64'(out_sat),   64'(mon_e.sat));
            check("out_beats", 64'(out_beats), 64'(mon_e.beats));
         end
      end
   end

   initial begin
      logic [15:0][WIDTH-1:0] v;
      int k;
      int glen;

      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = fill(32'd7);

      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         check("rst_out_valid", 64'(out_valid), 64'(0));
         check("rst_out_data",  64'(out_data),  64'(0));
         check("rst_out_sat",   64'(out_sat),   64'(0));
         check("rst_out_beats", 64'(out_beats), 64'(0));
         check("rst_busy",      64'(busy),      64'(0));
         check("rst_in_ready",  64'(in_ready),  64'(0));
         @(posedge clk);
      end
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'(1));
      check("post_rst_busy",     64'(busy),     64'(0));
      @(posedge clk);
      #1;

      // Single vector, lanes 1..16, with latency check.
      for (int i = 0; i < 16; i++) v[i] = 32'(i + 1);
      send(v, 1'b1);
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 20) begin
         k++;
         @(negedge clk);
      end
      check("single_latency", 64'(cyc - t_acc), 64'(5));
      check("single_data",    64'(out_data),    64'(136));
      check("single_beats",   64'(out_beats),   64'(1));
      @(posedge clk);
      #1;

      // Four-vector group of -3 lanes.
      for (int g = 0; g < 4; g++) send(fill(32'hFFFF_FFFD), 1'(g == 3));
      repeat (8) @(posedge clk);
      #1;

      // Positive and negative saturation.
      for (int g = 0; g < 3; g++) send(fill(32'h7FFF_FFFF), 1'(g == 2));
      send(fill(32'h8000_0000), 1'b1);
      repeat (8) @(posedge clk);
      #1;

      // Backpressure: three single-vector groups behind a stalled output.
      rdy_fixed = 1'b0;
      @(posedge clk);
      #2;
      send(fill(32'd1), 1'b1);
      send(fill(32'd2), 1'b1);
      send(fill(32'd3), 1'b1);
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 20) begin
         k++;
         @(negedge clk);
      end
      for (int c = 0; c < 8; c++) begin
         check("stall_in_ready",  64'(in_ready),  64'(0));
         check("stall_out_valid", 64'(out_valid), 64'(1));
         check("stall_out_data",  64'(out_data),  64'(16));
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rdy_fixed = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      // Reset with a half-built group in flight.
      send(fill(32'd5), 1'b0);
      send(fill(32'd5), 1'b0);
      rst_n  = 1'b0;
      m_open = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(fill(32'd1), 1'b1);
      repeat (8) @(posedge clk);
      #1;

      // Random groups under random output backpressure.
      rdy_rand = 1'b1;
      for (int g = 0; g < 8; g++) begin
         glen = int'($urandom_range(5, 1));
         for (int b = 0; b < glen; b++) begin
            for (int i = 0; i < 16; i++) v[i] = $urandom;
            send(v, 1'(b == glen - 1));
         end
      end
      rdy_rand = 1'b0;

      k = 0;
      while ((sb.size() != 0 || busy) && k < 300) begin
         k++;
         @(posedge clk);
      end
      @(negedge clk);
      check("drain_sb",   64'(sb.size()), 64'(0));
      check("drain_busy", 64'(busy),      64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
